// File: rtl/ysyx_25040111_axi_sram.sv
// ysyx_25040111_axi_sram
// Single-beat AXI4 subordinate memory model for non-SoC builds. Read and write
// channels are independent FSMs sharing one word array mapped at BASE.
// Optional macro YSYX_25040111_SRAM_RAND_DELAY_EN adds an LFSR-driven
// 0..7 cycle jitter to every response latency load.
module ysyx_25040111_axi_sram #(
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          DEPTH  = 1024,
    parameter int          RD_LAT = 1,
    parameter int          WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [3:0]  rid,
    output logic        rlast
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [2:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_WAIT, W_RESP} w_state_t;

    // A request is rejected when it falls outside the window, is a burst,
    // is wider than a word, or is not naturally aligned for its size.
    function automatic logic req_err(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [2:0] size);
        logic bad;
        bad = (addr < BASE) || ({1'b0, addr} >= LIMIT) || (len != 8'd0) || (size > 3'd2);
        if (size == 3'd1 && addr[0]) bad = 1'b1;
        if (size == 3'd2 && addr[1:0] != 2'b00) bad = 1'b1;
        return bad;
    endfunction

    logic [31:0] mem [DEPTH];

    r_state_t    r_state, r_next;
    w_state_t    w_state, w_next;
    logic [4:0]  rd_load, wr_load;
    logic [4:0]  r_cnt, w_cnt;

    logic [31:0] r_addr_q;
    logic        r_err_q;
    logic [31:0] rd_addr;
    logic        rd_err;
    logic [31:0] rd_off;

    logic [31:0] aw_addr_q;
    logic [3:0]  aw_id_q;
    logic [7:0]  aw_len_q;
    logic [2:0]  aw_size_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] wa_addr;
    logic [3:0]  wa_id;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        wr_err;
    logic        commit;
    logic [31:0] wr_off;

`ifdef YSYX_25040111_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    // Free-running LFSR (x^8+x^6+x^5+x^4+1) providing per-transaction jitter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign rd_load = 5'(RD_LAT) + {2'b00, lfsr[2:0]};
    assign wr_load = 5'(WR_LAT) + {2'b00, lfsr[2:0]};
`else
    assign rd_load = 5'(RD_LAT);
    assign wr_load = 5'(WR_LAT);
`endif

    // Handshake outputs are pure functions of state, never of valid
    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_RESP);
    assign rlast   = (r_state == R_RESP);
    assign awready = (w_state == W_IDLE) || (w_state == W_HAVE_D);
    assign wready  = (w_state == W_IDLE) || (w_state == W_HAVE_A);
    assign bvalid  = (w_state == W_RESP);

    // In idle the array lookup comes straight from the AR channel (zero-latency case)
    assign rd_addr = (r_state == R_IDLE) ? araddr : r_addr_q;
    assign rd_err  = (r_state == R_IDLE) ? req_err(araddr, arlen, arsize) : r_err_q;
    assign rd_off  = rd_addr - BASE;

    // Whichever phase arrived first comes from its latch, the other from the bus
    assign wa_addr = (w_state == W_HAVE_A) ? aw_addr_q : awaddr;
    assign wa_id   = (w_state == W_HAVE_A) ? aw_id_q   : awid;
    assign wr_err  = (w_state == W_HAVE_A) ? req_err(aw_addr_q, aw_len_q, aw_size_q)
                                           : req_err(awaddr, awlen, awsize);
    assign wd_data = (w_state == W_HAVE_D) ? w_data_q : wdata;
    assign wd_strb = (w_state == W_HAVE_D) ? w_strb_q : wstrb;
    assign wr_off  = wa_addr - BASE;
    assign commit  = ((w_state == W_IDLE) && awvalid && wvalid) ||
                     ((w_state == W_HAVE_A) && wvalid) ||
                     ((w_state == W_HAVE_D) && awvalid);

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read FSM next-state logic
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (arvalid) r_next = (rd_load != 5'd0) ? R_WAIT : R_RESP;
            R_WAIT: if (r_cnt == 5'd0) r_next = R_RESP;
            R_RESP: if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read request capture, latency countdown and response payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_q <= 32'h0;
            r_err_q  <= 1'b0;
            r_cnt    <= 5'd0;
            rid      <= 4'h0;
            rresp    <= 2'b00;
            rdata    <= 32'h0;
        end else begin
            if (r_state == R_IDLE && arvalid) begin
                r_addr_q <= araddr;
                r_err_q  <= rd_err;
                r_cnt    <= rd_load;
                rid      <= arid;
                rresp    <= rd_err ? 2'b10 : 2'b00;
            end else if (r_state == R_WAIT && r_cnt != 5'd0) begin
                r_cnt <= r_cnt - 5'd1;
            end
            if (r_next == R_RESP && r_state != R_RESP)
                rdata <= rd_err ? 32'h0 : mem[rd_off[AW+1:2]];
        end
    end

    // Write FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write FSM next-state logic
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (awvalid && wvalid) w_next = (wr_load != 5'd0) ? W_WAIT : W_RESP;
                else if (awvalid)      w_next = W_HAVE_A;
                else if (wvalid)       w_next = W_HAVE_D;
            end
            W_HAVE_A: if (wvalid)  w_next = (wr_load != 5'd0) ? W_WAIT : W_RESP;
            W_HAVE_D: if (awvalid) w_next = (wr_load != 5'd0) ? W_WAIT : W_RESP;
            W_WAIT:   if (w_cnt == 5'd0) w_next = W_RESP;
            W_RESP:   if (bready) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    // Phase latches, response id/status and write latency countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_addr_q <= 32'h0;
            aw_id_q   <= 4'h0;
            aw_len_q  <= 8'h0;
            aw_size_q <= 3'h0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
            w_cnt     <= 5'd0;
            bid       <= 4'h0;
            bresp     <= 2'b00;
        end else begin
            if (awvalid && awready) begin
                aw_addr_q <= awaddr;
                aw_id_q   <= awid;
                aw_len_q  <= awlen;
                aw_size_q <= awsize;
            end
            if (wvalid && wready) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) begin
                bid   <= wa_id;
                bresp <= wr_err ? 2'b10 : 2'b00;
                w_cnt <= wr_load;
            end else if (w_state == W_WAIT && w_cnt != 5'd0) begin
                w_cnt <= w_cnt - 5'd1;
            end
        end
    end

    // Array write under byte strobes; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (rst_n && commit && !wr_err) begin
            for (int b = 0; b < 4; b++)
                if (wd_strb[b]) mem[wr_off[AW+1:2]][8*b +: 8] <= wd_data[8*b +: 8];
        end
    end

    logic unused_ok;
    assign unused_ok = ^{awburst, arburst, wlast, rd_off[31:AW+2], rd_off[1:0],
                         wr_off[31:AW+2], wr_off[1:0]};

endmodule

// File: doc/ysyx_25040111_axi_sram.md
# ysyx_25040111_axi_sram

AXI4 single-beat subordinate (responder) memory model answering the LSU's and IFU's master-side AXI ports in non-SoC builds. It holds a synthesizable word array mapped at a fixed base address and services one read and one write transaction concurrently. Response latency is configurable per channel and, optionally, randomized to stress master handshakes. Byte lanes are handled with `wstrb`; read data is returned as the full aligned word, with lane extraction done by the master.

## Interface
- `BASE`, 32'h8000_0000: byte address of word 0.
- `DEPTH`, 1024: number of 32-bit words; power of two.
- `RD_LAT`, 1: extra cycles between AR handshake and `rvalid`; range 0..15.
- `WR_LAT`, 1: extra cycles between write capture and `bvalid`; range 0..15.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `awvalid`/`awready`  in/out  1/1  write-address handshake.
- `awaddr`, `awid`, `awlen`, `awsize`, `awburst`  in  32, 4, 8, 3, 2  write-address payload.
- `wvalid`/`wready`  in/out  1/1  write-data handshake.
- `wdata`, `wstrb`, `wlast`  in  32, 4, 1  write-data payload.
- `bvalid`/`bready`  out/in  1/1  write-response handshake.
- `bresp`, `bid`  out  2, 4  write-response payload.
- `arvalid`/`arready`  in/out  1/1  read-address handshake.
- `araddr`, `arid`, `arlen`, `arsize`, `arburst`  in  32, 4, 8, 3, 2  read-address payload.
- `rvalid`/`rready`  out/in  1/1  read-data handshake.
- `rdata`, `rresp`, `rid`, `rlast`  out  32, 2, 4, 1  read-data payload.

## Operation
- Read FSM states:
  - R_IDLE: `arready`=1. On `arvalid`: latch addr, id, and error flag; load counter with RD_LAT. Go to R_WAIT if RD_LAT≠0, else to R_RESP.
  - R_WAIT: decrement the counter each cycle; at 0, go to R_RESP.
  - R_RESP: `rvalid`=1 and `rlast`=1. Payload is held stable until `rready`; then return to R_IDLE.
- Write FSM states:
  - W_IDLE: `awready`=`wready`=1. AW and W may arrive in either order or in the same cycle. AW-only goes to W_HAVE_A; W-only goes to W_HAVE_D; both go straight to write.
  - W_HAVE_A: `awready`=0, `wready`=1.
  - W_HAVE_D: `awready`=1, `wready`=0.
  - Write: once both phases are captured, the array write is committed in that cycle, under `wstrb`. The FSM then enters W_WAIT with WR_LAT, or W_RESP if WR_LAT=0.
  - W_RESP: `bvalid`=1 until `bready`, then return to W_IDLE.
- Word index = (addr−BASE)[log2(DEPTH)+1:2]. `addr[1:0]` is ignored for indexing.
- Error (`resp`=2'b10, SLVERR) applies when any of these hold:
  - addr < BASE;
  - addr ≥ BASE+4·DEPTH;
  - `len`≠0;
  - `size`>2;
  - addr is misaligned for `size`.
- On error: no array write occurs and `rdata`=0. `rid`/`bid` still echo the request id.
- OKAY responses use `resp`=2'b00. `burst` is ignored.
- Read and write channels run independently. The array read for a response is sampled at entry to R_RESP.
  - If a write to the same word commits in that same cycle, the read returns the old data.
- `wlast`=0 with a single beat is accepted and not flagged.

## Timing
- Reset values, all outputs asserted on `rst_n`=0:
  - `awready`=`wready`=`arready`=1.
  - `rvalid`=`bvalid`=0.
  - `rdata`=0, `rresp`=`bresp`=0, `rid`=`bid`=0, `rlast`=0.
  - FSMs return to IDLE; the array contents are not reset.
- Read: AR handshake at edge T → `rvalid` rises after edge T+1+RD_LAT.
- Write: the later of the AW/W handshakes at edge T → array updated at T, `bvalid` rises after edge T+1+WR_LAT.
- Valid/ready rules:
  - Outputs hold while `valid` is high and `ready` is low.
  - `ready` never depends combinationally on `valid`.
  - Back-to-back transactions: the next AR/AW is accepted the cycle after the response handshake.
- Reset mid-transaction aborts it immediately. An in-flight write already committed stays in the array; no response is produced.

## Configuration
- `YSYX_25040111_SRAM_RAND_DELAY_EN` defined:
  - An 8-bit LFSR (polynomial x⁸+x⁶+x⁵+x⁴+1, reset seed 8'hA5, advancing every cycle) adds `lfsr[2:0]` (0..7) to each RD_LAT/WR_LAT counter load.
  - This makes latency vary per transaction.
- Macro undefined: no LFSR exists, and latency is exactly RD_LAT/WR_LAT.

## Test plan
- Word write then read, RD_LAT=WR_LAT=1, macro undefined:
  - Write 32'h1234_5678 to 32'h8000_0010 with `wstrb`=4'hF → `bvalid` at T+2, `bresp`=0.
  - Read the same address → `rdata`=32'h1234_5678, `rvalid` exactly at T+2.
- Byte write: `wdata`=32'h00AB_0000, `wstrb`=4'b0100 to 32'h8000_0012 on a word holding 32'h1234_5678 → subsequent read returns 32'h12AB_5678.
- W before AW: `wvalid` 3 cycles ahead of `awvalid` → `wready` drops after capture, write completes once AW arrives, `bid` echoes `awid`=4'h3.
- Error cases → each returns SLVERR:
  - `araddr`=32'h7FFF_FFFC → `rresp`=2'b10, `rdata`=0;
  - half-word write at 32'h8000_0001 → `bresp`=2'b10, memory unchanged.
- Backpressure: hold `rready`=0 for 5 cycles → `rvalid`, `rdata`, and `rid` stay stable, and `arready`=0 throughout.
- Reset mid-read: assert `rst_n`=0 during R_WAIT → `rvalid`=0 and `arready`=1 immediately. A fresh read after reset completes normally.
